// File: rtl/kernel_bd_rx.sv
// Kernel-side BD receiver: validates single-beat BDs, buffers them and issues them to the kernel under a credit limit.
// Optional sequence-number check enabled by defining KBD_SN_CHK_EN.
module kernel_bd_rx #(
    parameter int               A_DTH      = 5,
    parameter logic [A_DTH-1:0] FULL_LEVEL = 5'd28,
    parameter int               MAX_OUTS   = 8
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic [511:0] bd2k_s_axis_rq_tdata,
    input  logic [59:0]  bd2k_s_axis_rq_tuser,
    input  logic [63:0]  bd2k_s_axis_rq_tkeep,
    input  logic         bd2k_s_axis_rq_tlast,
    input  logic         bd2k_s_axis_rq_tvalid,
    output logic         bd2k_s_axis_rq_tready,
    output logic         kernel_bd_vld,
    output logic [511:0] kernel_bd_data,
    input  logic         kernel_bd_rdy,
    input  logic         kernel_bd_done,
    output logic [31:0]  kbd_rx_cnt,
    output logic [15:0]  kbd_drop_cnt,
    output logic [7:0]   kbd_outs_cnt,
    output logic [3:0]   kbd_sta
);
    localparam int         DEPTH      = 1 << A_DTH;
    localparam logic [7:0] MAX_OUTS_C = 8'(MAX_OUTS);

    typedef enum logic {RX_NORM, RX_DROP} rx_st_t;

    rx_st_t           r_st;
    logic             r_tready;
    logic             r_in_vld;
    logic [511:0]     r_in_data;
    logic [511:0]     r_mem [DEPTH];
    logic [A_DTH-1:0] r_wptr;
    logic [A_DTH-1:0] r_rptr;
    logic [A_DTH:0]   r_cnt;
    logic             r_head_full;
    logic [511:0]     r_head_data;
    logic [31:0]      r_rx_cnt;
    logic [15:0]      r_drop_cnt;
    logic [7:0]       r_outs;
    logic             r_uflow;

    logic             w_take;
    logic             w_good;
    logic             w_wr;
    logic             w_issue;
    logic             w_rd;
    logic [A_DTH:0]   w_cnt_nxt;
    logic [A_DTH:0]   w_occ;
    logic [A_DTH:0]   w_occ_nxt;
    logic             w_sn_err;
    logic             w_unused_tuser;

    assign w_take    = bd2k_s_axis_rq_tvalid & r_tready;
    assign w_good    = bd2k_s_axis_rq_tlast & (&bd2k_s_axis_rq_tkeep);
    assign w_wr      = w_take & (r_st == RX_NORM) & w_good;
    assign w_issue   = kernel_bd_vld & kernel_bd_rdy;
    // Head refills from the FIFO whenever it is empty or being consumed this cycle.
    assign w_rd      = (r_cnt != '0) & (~r_head_full | w_issue);
    assign w_cnt_nxt = r_cnt + {{A_DTH{1'b0}}, r_in_vld} - {{A_DTH{1'b0}}, w_rd};
    // Occupancy counts the write staged in r_in so back-pressure covers it too.
    assign w_occ     = r_cnt + {{A_DTH{1'b0}}, r_in_vld};
    assign w_occ_nxt = w_cnt_nxt + {{A_DTH{1'b0}}, w_wr};

    assign w_unused_tuser = ^bd2k_s_axis_rq_tuser;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_st       <= RX_NORM;
            r_in_vld   <= 1'b0;
            r_in_data  <= '0;
            r_rx_cnt   <= '0;
            r_drop_cnt <= '0;
            r_tready   <= 1'b0;
        end else begin
            r_in_vld <= w_wr;
            if (w_wr)
                r_in_data <= bd2k_s_axis_rq_tdata;
            r_tready <= (w_occ_nxt < {1'b0, FULL_LEVEL});
            if (w_take) begin
                unique case (r_st)
                    RX_NORM: begin
                        if (w_good) begin
                            r_rx_cnt <= r_rx_cnt + 32'd1;
                        end else begin
                            if (r_drop_cnt != 16'hFFFF)
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            if (!bd2k_s_axis_rq_tlast)
                                r_st <= RX_DROP;
                        end
                    end
                    RX_DROP: begin
                        if (bd2k_s_axis_rq_tlast)
                            r_st <= RX_NORM;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (r_in_vld)
            r_mem[r_wptr] <= r_in_data;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_head_full <= 1'b0;
            r_head_data <= '0;
        end else begin
            if (r_in_vld)
                r_wptr <= r_wptr + A_DTH'(1);
            if (w_rd)
                r_rptr <= r_rptr + A_DTH'(1);
            r_cnt <= w_cnt_nxt;
            if (w_rd) begin
                r_head_full <= 1'b1;
                r_head_data <= r_mem[r_rptr];
            end else if (w_issue) begin
                r_head_full <= 1'b0;
            end
        end
    end

    // Issue and completion in the same cycle cancel; a done with nothing outstanding is flagged.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_outs  <= '0;
            r_uflow <= 1'b0;
        end else begin
            unique case ({w_issue, kernel_bd_done})
                2'b10: r_outs <= r_outs + 8'd1;
                2'b01: begin
                    if (r_outs == '0)
                        r_uflow <= 1'b1;
                    else
                        r_outs <= r_outs - 8'd1;
                end
                default: r_outs <= r_outs;
            endcase
        end
    end

`ifdef KBD_SN_CHK_EN
    logic        r_sn_seen;
    logic [10:0] r_sn_exp;
    logic        r_sn_err;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_sn_seen <= 1'b0;
            r_sn_exp  <= '0;
            r_sn_err  <= 1'b0;
        end else if (w_wr) begin
            r_sn_seen <= 1'b1;
            r_sn_exp  <= bd2k_s_axis_rq_tdata[10:0] + 11'd1;
            if (r_sn_seen && (bd2k_s_axis_rq_tdata[10:0] != r_sn_exp))
                r_sn_err <= 1'b1;
        end
    end

    assign w_sn_err = r_sn_err;
`else
    assign w_sn_err = 1'b0;
`endif

    assign bd2k_s_axis_rq_tready = r_tready;
    assign kernel_bd_vld         = r_head_full & (r_outs < MAX_OUTS_C);
    assign kernel_bd_data        = r_head_data;
    assign kbd_rx_cnt            = r_rx_cnt;
    assign kbd_drop_cnt          = r_drop_cnt;
    assign kbd_outs_cnt          = r_outs;
    assign kbd_sta               = {w_sn_err, r_uflow, (r_st == RX_DROP), (w_occ >= {1'b0, FULL_LEVEL})};

endmodule

// File: tb/tb_kernel_bd_rx.sv
// Self-checking bench for kernel_bd_rx: random BDs against a packet-level reference model.
// Build with KBD_SN_CHK_EN defined to also exercise the sequence-number check.
module tb_kernel_bd_rx;
    logic         clk_sys = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] bd2k_s_axis_rq_tdata = '0;
    logic [59:0]  bd2k_s_axis_rq_tuser = '0;
    logic [63:0]  bd2k_s_axis_rq_tkeep = '0;
    logic         bd2k_s_axis_rq_tlast = 1'b0;
    logic         bd2k_s_axis_rq_tvalid = 1'b0;
    logic         bd2k_s_axis_rq_tready;
    logic         kernel_bd_vld;
    logic [511:0] kernel_bd_data;
    logic         kernel_bd_rdy = 1'b0;
    logic         kernel_bd_done = 1'b0;
    logic [31:0]  kbd_rx_cnt;
    logic [15:0]  kbd_drop_cnt;
    logic [7:0]   kbd_outs_cnt;
    logic [3:0]   kbd_sta;

    localparam logic [63:0] KEEP_ALL = {64{1'b1}};

    kernel_bd_rx dut (
        .clk_sys(clk_sys), .rst(rst),
        .bd2k_s_axis_rq_tdata(bd2k_s_axis_rq_tdata), .bd2k_s_axis_rq_tuser(bd2k_s_axis_rq_tuser),
        .bd2k_s_axis_rq_tkeep(bd2k_s_axis_rq_tkeep), .bd2k_s_axis_rq_tlast(bd2k_s_axis_rq_tlast),
        .bd2k_s_axis_rq_tvalid(bd2k_s_axis_rq_tvalid), .bd2k_s_axis_rq_tready(bd2k_s_axis_rq_tready),
        .kernel_bd_vld(kernel_bd_vld), .kernel_bd_data(kernel_bd_data),
        .kernel_bd_rdy(kernel_bd_rdy), .kernel_bd_done(kernel_bd_done),
        .kbd_rx_cnt(kbd_rx_cnt), .kbd_drop_cnt(kbd_drop_cnt),
        .kbd_outs_cnt(kbd_outs_cnt), .kbd_sta(kbd_sta)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    int m_rx, m_drop, m_outs, acc_cnt, stab_err, first_acc_edge, first_vld_edge;
    bit m_in_drop, m_uflow, stream_done;
    logic p_vld = 1'b0;
    logic p_rdy = 1'b0;
    logic [511:0] p_data = '0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Reference model: observes handshakes mid-cycle, applies the packet rules at BD level.
    always @(negedge clk_sys) begin
        if (rst) begin
            p_vld = 1'b0;
        end else begin
            if (p_vld && !p_rdy && (!kernel_bd_vld || kernel_bd_data !== p_data)) stab_err++;
            p_vld = kernel_bd_vld; p_rdy = kernel_bd_rdy; p_data = kernel_bd_data;
            if (bd2k_s_axis_rq_tvalid && bd2k_s_axis_rq_tready) begin
                acc_cnt++;
                if (first_acc_edge < 0) first_acc_edge = cyc + 1;
                if (m_in_drop) begin
                    if (bd2k_s_axis_rq_tlast) m_in_drop = 1'b0;
                end else if (bd2k_s_axis_rq_tlast && bd2k_s_axis_rq_tkeep == KEEP_ALL) begin
                    exp_q.push_back(bd2k_s_axis_rq_tdata);
                    m_rx++;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    if (!bd2k_s_axis_rq_tlast) m_in_drop = 1'b1;
                end
            end
            if (kernel_bd_vld && first_vld_edge < 0) first_vld_edge = cyc;
            if (kernel_bd_vld && kernel_bd_rdy) begin
                got_q.push_back(kernel_bd_data);
                if (!kernel_bd_done) m_outs++;
            end else if (kernel_bd_done) begin
                if (m_outs == 0) m_uflow = 1'b1;
                else m_outs--;
            end
        end
    end

    function automatic logic [511:0] rand_bd();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete(); got_q.delete();
        m_rx = 0; m_drop = 0; m_outs = 0; m_in_drop = 0; m_uflow = 0;
        acc_cnt = 0; stab_err = 0; first_acc_edge = -1; first_vld_edge = -1;
    endtask

    task automatic reset_dut();
        tick(1);
        rst = 1'b1; bd2k_s_axis_rq_tvalid = 1'b0; kernel_bd_rdy = 1'b0; kernel_bd_done = 1'b0;
        tick(3);
        clear_model();
        rst = 1'b0;
    endtask

    // Caller must be just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
        int n = 0;
        bd2k_s_axis_rq_tdata = d; bd2k_s_axis_rq_tkeep = k; bd2k_s_axis_rq_tlast = l;
        bd2k_s_axis_rq_tuser = 60'($urandom());
        bd2k_s_axis_rq_tvalid = 1'b1;
        @(negedge clk_sys);
        while (!bd2k_s_axis_rq_tready && n < 500) begin @(negedge clk_sys); n++; end
        if (!bd2k_s_axis_rq_tready) begin
            n_chk++; $display("FAIL send_beat_timeout tready=0 required=1");
        end
        tick(1);
        bd2k_s_axis_rq_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        @(negedge clk_sys);
        n_chk++; if (bd2k_s_axis_rq_tready !== 1'b0) $display("FAIL rst_tready got=%b exp=0", bd2k_s_axis_rq_tready); else n_pass++;
        n_chk++; if (kernel_bd_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", kernel_bd_vld); else n_pass++;
        n_chk++; if (kernel_bd_data !== '0) $display("FAIL rst_data got=%h exp=0", kernel_bd_data); else n_pass++;
        n_chk++; if ({kbd_rx_cnt, kbd_drop_cnt, kbd_outs_cnt} !== 56'd0) $display("FAIL rst_counters got=%h exp=0", {kbd_rx_cnt, kbd_drop_cnt, kbd_outs_cnt}); else n_pass++;
        n_chk++; if (kbd_sta !== 4'd0) $display("FAIL rst_sta got=%b exp=0000", kbd_sta); else n_pass++;
        tick(1);
        clear_model();
        rst = 1'b0;
        tick(1);
        n_chk++; if (bd2k_s_axis_rq_tready !== 1'b1) $display("FAIL rst_tready_rise got=%b exp=1", bd2k_s_axis_rq_tready); else n_pass++;
    endtask

    task automatic test_basic();
        int bad = 0;
        reset_dut();
        kernel_bd_rdy = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(rand_bd(), KEEP_ALL, 1'b1);
        tick(10);
        @(negedge clk_sys);
        n_chk++; if (first_vld_edge !== first_acc_edge + 2) $display("FAIL basic_latency got_edge=%0d exp_edge=%0d", first_vld_edge, first_acc_edge + 2); else n_pass++;
        n_chk++; if (kbd_rx_cnt !== 32'd3) $display("FAIL basic_rx_cnt got=%0d exp=3", kbd_rx_cnt); else n_pass++;
        n_chk++; if (kbd_outs_cnt !== 8'd3) $display("FAIL basic_outs got=%0d exp=3", kbd_outs_cnt); else n_pass++;
        n_chk++; if (got_q.size() !== 3) $display("FAIL basic_issued got=%0d exp=3", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_chk++; if (bad != 0) $display("FAIL basic_order bad=%0d exp=0", bad); else n_pass++;
    endtask

    task automatic test_drop_multi();
        logic [511:0] good;
        reset_dut();
        kernel_bd_rdy = 1'b1;
        send_beat(rand_bd(), KEEP_ALL, 1'b0);
        send_beat(rand_bd(), KEEP_ALL, 1'b0);
        n_chk++; if (kbd_sta[1] !== 1'b1) $display("FAIL multi_drop_state got=%b exp=1", kbd_sta[1]); else n_pass++;
        send_beat(rand_bd(), KEEP_ALL, 1'b1);
        good = rand_bd();
        send_beat(good, KEEP_ALL, 1'b1);
        tick(6);
        n_chk++; if (kbd_drop_cnt !== 16'd1) $display("FAIL multi_drop_cnt got=%0d exp=1", kbd_drop_cnt); else n_pass++;
        n_chk++; if (kbd_sta[1] !== 1'b0) $display("FAIL multi_back_norm got=%b exp=0", kbd_sta[1]); else n_pass++;
        n_chk++; if (got_q.size() !== 1) $display("FAIL multi_issued got=%0d exp=1", got_q.size()); else n_pass++;
        n_chk++; if (got_q.size() != 1 || got_q[0] !== good) $display("FAIL multi_good_data got_n=%0d exp_n=1", got_q.size()); else n_pass++;
    endtask

    task automatic test_keep();
        reset_dut();
        kernel_bd_rdy = 1'b1;
        send_beat(rand_bd(), 64'h0000_FFFF_FFFF_FFFF, 1'b1);
        tick(6);
        n_chk++; if (kbd_drop_cnt !== 16'd1) $display("FAIL keep_drop_cnt got=%0d exp=1", kbd_drop_cnt); else n_pass++;
        n_chk++; if (got_q.size() !== 0 || kbd_rx_cnt !== 32'd0) $display("FAIL keep_no_issue issued=%0d rx=%0d exp=0", got_q.size(), kbd_rx_cnt); else n_pass++;
        n_chk++; if (kbd_sta[1] !== 1'b0) $display("FAIL keep_state got=%b exp=0", kbd_sta[1]); else n_pass++;
    endtask

    task automatic test_credit();
        int bad = 0;
        reset_dut();
        kernel_bd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) send_beat(rand_bd(), KEEP_ALL, 1'b1);
        tick(12);
        @(negedge clk_sys);
        n_chk++; if (got_q.size() !== 8) $display("FAIL credit_issued got=%0d exp=8", got_q.size()); else n_pass++;
        n_chk++; if (kernel_bd_vld !== 1'b0) $display("FAIL credit_vld_low got=%b exp=0", kernel_bd_vld); else n_pass++;
        n_chk++; if (kbd_outs_cnt !== 8'd8) $display("FAIL credit_outs got=%0d exp=8", kbd_outs_cnt); else n_pass++;
        tick(1);
        kernel_bd_done = 1'b1;
        tick(1);
        kernel_bd_done = 1'b0;
        @(negedge clk_sys);
        n_chk++; if (kernel_bd_vld !== 1'b1) $display("FAIL credit_ninth_vld got=%b exp=1", kernel_bd_vld); else n_pass++;
        tick(1);
        @(negedge clk_sys);
        n_chk++; if (kbd_outs_cnt !== 8'd8) $display("FAIL credit_outs_after got=%0d exp=8", kbd_outs_cnt); else n_pass++;
        tick(1);
        kernel_bd_done = 1'b1;
        tick(1);
        kernel_bd_done = 1'b0;
        tick(4);
        n_chk++; if (got_q.size() !== 10) $display("FAIL credit_all_issued got=%0d exp=10", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_chk++; if (bad != 0) $display("FAIL credit_order bad=%0d exp=0", bad); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        int bad = 0;
        reset_dut();
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_beat(rand_bd(), KEEP_ALL, 1'b1);
                stream_done = 1'b1;
            end
            begin
                tick(80);
                @(negedge clk_sys);
                n_chk++; if (bd2k_s_axis_rq_tready !== 1'b0) $display("FAIL bp_tready got=%b exp=0", bd2k_s_axis_rq_tready); else n_pass++;
                n_chk++; if (acc_cnt < 28 || acc_cnt > 32) $display("FAIL bp_accepted got=%0d exp=28..32", acc_cnt); else n_pass++;
                n_chk++; if (kbd_sta[0] !== 1'b1) $display("FAIL bp_full got=%b exp=1", kbd_sta[0]); else n_pass++;
                tick(1);
                while (!(stream_done && got_q.size() == exp_q.size()) && n < 3000) begin
                    kernel_bd_rdy = 1'($urandom_range(0, 1));
                    kernel_bd_done = (m_outs > 0) && ($urandom_range(0, 2) == 0);
                    tick(1);
                    n++;
                end
                kernel_bd_rdy = 1'b0; kernel_bd_done = 1'b0;
                if (n >= 3000) begin n_chk++; $display("FAIL bp_drain_timeout issued=%0d exp=40", got_q.size()); end
            end
        join
        tick(2);
        n_chk++; if (kbd_rx_cnt !== 32'd40) $display("FAIL bp_rx_cnt got=%0d exp=40", kbd_rx_cnt); else n_pass++;
        n_chk++; if (got_q.size() !== 40) $display("FAIL bp_issued got=%0d exp=40", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_chk++; if (bad != 0) $display("FAIL bp_order bad=%0d exp=0", bad); else n_pass++;
        n_chk++; if (stab_err != 0) $display("FAIL bp_hold_stable violations=%0d exp=0", stab_err); else n_pass++;
        n_chk++; if (kbd_outs_cnt !== 8'(m_outs)) $display("FAIL bp_outs got=%0d exp=%0d", kbd_outs_cnt, m_outs); else n_pass++;
    endtask

    task automatic test_random();
        int n = 0;
        int bad = 0;
        reset_dut();
        stream_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 60; p++) begin
                    int kind = $urandom_range(0, 9);
                    int nb = (kind == 8) ? $urandom_range(2, 3) : 1;
                    for (int b = 0; b < nb; b++) begin
                        logic [63:0] k = KEEP_ALL;
                        if (kind == 7 || (kind == 8 && $urandom_range(0, 1) == 1)) k[$urandom_range(0, 63)] = 1'b0;
                        send_beat(rand_bd(), k, (b == nb - 1));
                    end
                    tick($urandom_range(0, 2));
                end
                stream_done = 1'b1;
            end
            begin
                while (!(stream_done && got_q.size() == exp_q.size()) && n < 3000) begin
                    kernel_bd_rdy = 1'($urandom_range(0, 1));
                    kernel_bd_done = (m_outs > 0) && ($urandom_range(0, 1) == 1);
                    tick(1);
                    n++;
                end
                kernel_bd_rdy = 1'b0; kernel_bd_done = 1'b0;
                if (n >= 3000) begin n_chk++; $display("FAIL rnd_drain_timeout issued=%0d exp=%0d", got_q.size(), exp_q.size()); end
            end
        join
        tick(2);
        n_chk++; if (kbd_rx_cnt !== 32'(m_rx)) $display("FAIL rnd_rx_cnt got=%0d exp=%0d", kbd_rx_cnt, m_rx); else n_pass++;
        n_chk++; if (kbd_drop_cnt !== 16'(m_drop)) $display("FAIL rnd_drop_cnt got=%0d exp=%0d", kbd_drop_cnt, m_drop); else n_pass++;
        n_chk++; if (kbd_outs_cnt !== 8'(m_outs)) $display("FAIL rnd_outs got=%0d exp=%0d", kbd_outs_cnt, m_outs); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_chk++; if (bad != 0 || got_q.size() != exp_q.size()) $display("FAIL rnd_order bad=%0d n=%0d exp_n=%0d", bad, got_q.size(), exp_q.size()); else n_pass++;
        n_chk++; if (stab_err != 0) $display("FAIL rnd_hold_stable violations=%0d exp=0", stab_err); else n_pass++;
        n_chk++; if (kbd_sta[2:1] !== {m_uflow, m_in_drop}) $display("FAIL rnd_sta got=%b exp=%b", kbd_sta[2:1], {m_uflow, m_in_drop}); else n_pass++;
    endtask

    task automatic test_underflow();
        reset_dut();
        kernel_bd_done = 1'b1;
        tick(1);
        kernel_bd_done = 1'b0;
        @(negedge clk_sys);
        n_chk++; if (kbd_outs_cnt !== 8'd0) $display("FAIL uflow_outs got=%0d exp=0", kbd_outs_cnt); else n_pass++;
        n_chk++; if (kbd_sta[2] !== 1'b1) $display("FAIL uflow_sticky got=%b exp=1", kbd_sta[2]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [511:0] d;
        reset_dut();
        for (int i = 0; i < 5; i++) send_beat(rand_bd(), KEEP_ALL, 1'b1);
        send_beat(rand_bd(), KEEP_ALL, 1'b0);
        tick(4);
        reset_dut();
        @(negedge clk_sys);
        n_chk++; if (kernel_bd_vld !== 1'b0 || kbd_outs_cnt !== 8'd0) $display("FAIL mid_rst_out vld=%b outs=%0d exp=0", kernel_bd_vld, kbd_outs_cnt); else n_pass++;
        n_chk++; if (kbd_sta !== 4'd0 || kbd_rx_cnt !== 32'd0) $display("FAIL mid_rst_state sta=%b rx=%0d exp=0", kbd_sta, kbd_rx_cnt); else n_pass++;
        tick(1);
        kernel_bd_rdy = 1'b1;
        d = rand_bd();
        send_beat(d, KEEP_ALL, 1'b1);
        tick(6);
        n_chk++; if (got_q.size() != 1 || got_q[0] !== d) $display("FAIL mid_rst_fresh issued=%0d exp=1", got_q.size()); else n_pass++;
    endtask

`ifdef KBD_SN_CHK_EN
    task automatic test_sn();
        int sns[4] = '{5, 6, 8, 9};
        bit seeded = 1'b0;
        bit err = 1'b0;
        int expect_sn = 0;
        int bad = 0;
        logic [511:0] d;
        reset_dut();
        kernel_bd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (seeded && sns[i] != expect_sn) err = 1'b1;
            seeded = 1'b1;
            expect_sn = (sns[i] + 1) % 2048;
            d = rand_bd();
            d[10:0] = 11'(sns[i]);
            send_beat(d, KEEP_ALL, 1'b1);
            n_chk++; if (kbd_sta[3] !== err) $display("FAIL sn_err_%0d got=%b exp=%b", sns[i], kbd_sta[3], err); else n_pass++;
        end
        tick(8);
        n_chk++; if (got_q.size() !== 4) $display("FAIL sn_forwarded got=%0d exp=4", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        n_chk++; if (bad != 0) $display("FAIL sn_order bad=%0d exp=0", bad); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_drop_multi();
        test_keep();
        test_credit();
        test_backpressure();
        test_underflow();
        test_random();
        test_reset_mid();
`ifdef KBD_SN_CHK_EN
        test_sn();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t limit=2000000", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/kernel_bd_rx.md
Name: kernel_bd_rx

Overview:
- Consumes the 512-bit single-beat BD stream that the TX BD path sends toward the kernel, i.e. the bd2k_s_axis_rq_* interface.
- Validates each BD, buffers it in an internal FIFO and presents it to the kernel over a valid/ready command port.
- Credit-limits the number of BDs the kernel holds concurrently, and exports DFX counters and status.

Parameters:
- A_DTH, 5, log2 of BD buffer depth; depth is 32 entries.
- FULL_LEVEL, 5'd28, fill count at or above which tready deasserts.
- MAX_OUTS, 8, maximum BDs issued to the kernel and not yet completed. Range 1..255.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- bd2k_s_axis_rq_tdata  in  512  BD payload.
- bd2k_s_axis_rq_tuser  in  60  sideband; not interpreted.
- bd2k_s_axis_rq_tkeep  in  64  byte enables.
- bd2k_s_axis_rq_tlast  in  1  end of BD.
- bd2k_s_axis_rq_tvalid  in  1  beat valid.
- bd2k_s_axis_rq_tready  out  1  beat accept.
- kernel_bd_vld  out  1  BD available to the kernel.
- kernel_bd_data  out  512  BD to the kernel.
- kernel_bd_rdy  in  1  kernel takes the BD.
- kernel_bd_done  in  1  one-cycle pulse; kernel finished one BD.
- kbd_rx_cnt  out  32  BDs accepted into the FIFO.
- kbd_drop_cnt  out  16  malformed BDs dropped; saturating.
- kbd_outs_cnt  out  8  BDs currently outstanding at the kernel.
- kbd_sta  out  4  {sn_err sticky, done_underflow sticky, drop_state, fifo_full}.

Behaviour:
- Reset: tready=0, kernel_bd_vld=0, kernel_bd_data=0, all counters=0, sticky bits=0, FSM=RX_NORM, FIFO empty. tready rises on the first cycle after rst deasserts.
- Handshake: a beat is taken when tvalid & tready.
  - tready = (fifo_cnt < FULL_LEVEL), registered.
  - The 4 entries of headroom absorb in-flight beats; a write is never lost and the FIFO never overflows.
- Input FSM, state RX_NORM:
  - A taken beat with tlast=1 and tkeep=64'hFFFF_FFFF_FFFF_FFFF is written to the FIFO; kbd_rx_cnt increments.
  - A taken beat with tlast=1 and any other tkeep is not written; kbd_drop_cnt increments.
  - A taken beat with tlast=0 is not written; kbd_drop_cnt increments; FSM goes to RX_DROP.
- Input FSM, state RX_DROP:
  - All taken beats are discarded and tready stays governed by the fill rule.
  - A taken beat with tlast=1 returns the FSM to RX_NORM. No further count for that packet.
- Output stage:
  - Registered head; the FIFO feeds an output register.
  - kernel_bd_vld asserts when the head register is loaded and kbd_outs_cnt < MAX_OUTS.
  - Minimum latency: accepted beat at edge N gives kernel_bd_vld=1 after edge N+2.
  - Once asserted, kernel_bd_vld and kernel_bd_data hold stable until kernel_bd_rdy.
  - Back-to-back issue at 1 BD per cycle when the FIFO holds data and credit is available.
- Credit counter, kbd_outs_cnt:
  - +1 on kernel_bd_vld & kernel_bd_rdy; -1 on kernel_bd_done.
  - Both in the same cycle: unchanged.
  - done while the count is 0: count stays 0 and done_underflow latches.
  - At MAX_OUTS, vld deasserts the next cycle; a same-cycle done allows the issue to continue.
- Counters:
  - kbd_rx_cnt wraps at 2^32.
  - kbd_drop_cnt saturates at 16'hFFFF.
- Simultaneous FIFO write and read at full or empty boundaries are both honoured. Reading an empty FIFO is impossible by construction.
- Reset mid-packet or mid-issue: FIFO contents, head register, FSM and credits are all discarded. Upstream and kernel are reset together.

Optional Feature:
- Macro: KBD_SN_CHK_EN.
- Defined:
  - BD bits [10:0] carry an 11-bit sequence number, checked on each BD written to the FIFO.
  - The first BD after reset seeds the expected value. Each following BD must equal previous+1 mod 2048.
  - On mismatch: sn_err latches and the expected value resyncs to received+1. The BD is still forwarded.
- Undefined: no check logic; kbd_sta[3] is tied to 0.

Test Plan:
- Send 3 single-beat BDs, full tkeep, kernel_bd_rdy=1 -> 3 issues in order; first kernel_bd_vld 2 cycles after first accept; kbd_rx_cnt=3; kbd_outs_cnt=3.
- Send a 3-beat packet (tlast on beat 3), then 1 good BD -> kbd_drop_cnt=1; only the good BD issued; FSM back in RX_NORM.
- Send 1 BD with tkeep=64'h0000_FFFF_FFFF_FFFF -> dropped; kbd_drop_cnt=1; no issue.
- MAX_OUTS=8, kernel_bd_rdy=1, no done, 10 BDs -> exactly 8 issued and vld=0. Then one done pulse -> 9th issues next cycle; kbd_outs_cnt=8.
- kernel_bd_rdy=0, stream 40 BDs -> tready drops once fifo_cnt reaches 28; no loss. Release rdy with done pulses -> all accepted BDs issued, kbd_rx_cnt=40 eventually.
- With KBD_SN_CHK_EN, send sn 5,6,8,9 -> sn_err set at BD 8; no further error at 9; all 4 forwarded.
